// File: rtl/umi_demux_if.sv
// Bus bundle for the UMI one-hot demultiplexer: one shared input stream,
// N registered output streams, and the dropped-packet error counter.
interface umi_demux_if #(
  parameter int UW = 256,
  parameter int N  = 4,
  parameter int CW = 8
);
  logic [N-1:0]    umi_in_sel;
  logic            umi_in_valid;
  logic [UW-1:0]   umi_in_packet;
  logic            umi_in_ready;
  logic [N-1:0]    umi_out_valid;
  logic [N*UW-1:0] umi_out_packet;
  logic [N-1:0]    umi_out_ready;
  logic            err_clear;
  logic [CW-1:0]   err_count;

  // Source / agent side that drives packets in and sinks them out
  modport master (
    output umi_in_sel, umi_in_valid, umi_in_packet, umi_out_ready, err_clear,
    input  umi_in_ready, umi_out_valid, umi_out_packet, err_count
  );

  // Demultiplexer side
  modport slave (
    input  umi_in_sel, umi_in_valid, umi_in_packet, umi_out_ready, err_clear,
    output umi_in_ready, umi_out_valid, umi_out_packet, err_count
  );
endinterface

// File: rtl/umi_demux.sv
// One-hot UMI demultiplexer: routes a single input stream to one of N
// outputs through a single-entry registered stage per output. Packets with
// a zero or multi-hot select are consumed and counted in a saturating
// error counter.
module umi_demux #(
  parameter int UW = 256,
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        nreset,
  umi_demux_if.slave  bus
);

  localparam logic [N-1:0]  SEL_ONE = N'(1);
  localparam logic [CW-1:0] ERR_ONE = CW'(1);
  localparam logic [CW-1:0] ERR_MAX = '1;

  logic                  legal;
  logic                  in_ready;
  logic                  drop;
  logic [N-1:0]          slot_free;
  logic [N-1:0]          accept;
  logic [N-1:0]          valid_d, valid_q;
  logic [N-1:0][UW-1:0]  pkt_d, pkt_q;
  logic [CW-1:0]         err_d, err_q;

  // Decode select legality and the input handshake; a slot draining this cycle may refill
  always_comb begin
    legal     = (bus.umi_in_sel != '0) &&
                ((bus.umi_in_sel & (bus.umi_in_sel - SEL_ONE)) == '0);
    slot_free = ~valid_q | bus.umi_out_ready;
    in_ready  = legal ? |(bus.umi_in_sel & slot_free) : 1'b1;
    accept    = (bus.umi_in_valid && in_ready && legal) ? bus.umi_in_sel : '0;
    drop      = bus.umi_in_valid & ~legal;
  end

  // Per-output slot: load on accept, clear valid on drain, hold payload otherwise
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    for (int i = 0; i < N; i++) begin
      if (accept[i]) begin
        valid_d[i] = 1'b1;
        pkt_d[i]   = bus.umi_in_packet;
      end else if (bus.umi_out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Saturating drop counter; a clear coinciding with a drop leaves a count of one
  always_comb begin
    err_d = err_q;
    if (bus.err_clear) begin
      err_d = drop ? ERR_ONE : '0;
    end else if (drop && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_ONE;
    end
  end

  // State registers; payloads are reset too so outputs never carry X
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign bus.umi_in_ready   = in_ready;
  assign bus.umi_out_valid  = valid_q;
  assign bus.umi_out_packet = pkt_q;
  assign bus.err_count      = err_q;

endmodule
